// File: rtl/npc_pc_unit.sv
// ---------------------------------------------------------------------------
// npc_pc_unit
//
// Program-counter stage. Holds the fetch PC, computes the next PC from the
// NPCOp select, and advances once per retired instruction. It also tracks a
// small RUN/HALT/TRAP state machine and counts retired instructions so a
// bench can detect end-of-test.
//
// Optional build feature: define NPC_BNE_EN to decode NPCOp=3'b100 as BNE.
// Without it, 3'b100 falls back to PC+4 like every other unused encoding.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   NPCOp     in   [2:0] next-PC select (000 PC4, 001 BEQ, 010 J/JAL,
//                  011 JR, 100 BNE when NPC_BNE_EN, others PC4)
//   Zero      in   ALU equality flag, used by the branch decision
//   imm16     in   [15:0] branch offset in words
//   target26  in   [25:0] jump index field
//   rs_data   in   [31:0] jr target
//   stall     in   hold PC; current instruction does not retire
//   halt_req  in   current instruction is a syscall/halt
//   pc        out  [31:0] current fetch address
//   pc_plus4  out  [31:0] pc+4, combinational (jal link value)
//   halted    out  registered HALT state flag
//   trap      out  registered TRAP state flag
//   trap_pc   out  [31:0] PC of the jr that faulted
//   instret   out  [INSTRET_W-1:0] retired-instruction count
//
// Control inputs are sampled on the rising edge; the state/pc/instret update
// uses the combinational next-state below and is visible after that edge.
// ---------------------------------------------------------------------------
module npc_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           NPCOp,
  input  logic                 Zero,
  input  logic [15:0]          imm16,
  input  logic [25:0]          target26,
  input  logic [31:0]          rs_data,
  input  logic                 stall,
  input  logic                 halt_req,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 halted,
  output logic                 trap,
  output logic [31:0]          trap_pc,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [2:0] OP_PC4 = 3'b000;
  localparam logic [2:0] OP_BEQ = 3'b001;
  localparam logic [2:0] OP_J   = 3'b010;
  localparam logic [2:0] OP_JR  = 3'b011;
  localparam logic [2:0] OP_BNE = 3'b100;

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          trap_pc_q, trap_pc_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 halted_q, trap_q;

  logic [31:0] branch_target;
  logic [31:0] npc;
  logic        jr_misaligned;

  // Word offset sign-extended and scaled to bytes; arithmetic wraps mod 2^32.
  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign jr_misaligned = (NPCOp == OP_JR) && (rs_data[1:0] != 2'b00);

  always_comb begin
    npc = pc_plus4;
    case (NPCOp)
      OP_PC4: npc = pc_plus4;
      OP_BEQ: npc = Zero ? branch_target : pc_plus4;
      OP_J:   npc = {pc_plus4[31:28], target26, 2'b00};
      OP_JR:  npc = rs_data;
`ifdef NPC_BNE_EN
      OP_BNE: npc = Zero ? pc_plus4 : branch_target;
`else
      OP_BNE: npc = pc_plus4;
`endif
      default: npc = pc_plus4;
    endcase
  end

  // Next-state logic. Priority within RUN: stall, halt, jr fault, advance.
  // A stalled instruction is not retiring, so its halt_req and any jr fault
  // are deliberately ignored until it is presented again without stall.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    trap_pc_d = trap_pc_q;
    instret_d = instret_q;
    case (state_q)
      ST_RUN: begin
        if (stall) begin
          state_d = ST_RUN;
        end else if (halt_req) begin
          state_d   = ST_HALT;
          instret_d = instret_q + INSTRET_ONE;
        end else if (jr_misaligned) begin
          state_d   = ST_TRAP;
          trap_pc_d = pc_q;
        end else begin
          pc_d      = npc;
          instret_d = instret_q + INSTRET_ONE;
        end
      end
      ST_HALT: state_d = ST_HALT;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      trap_pc_q <= 32'h0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_pc_q <= trap_pc_d;
      instret_q <= instret_d;
      halted_q  <= (state_d == ST_HALT);
      trap_q    <= (state_d == ST_TRAP);
    end
  end

  assign pc      = pc_q;
  assign halted  = halted_q;
  assign trap    = trap_q;
  assign trap_pc = trap_pc_q;
  assign instret = instret_q;

endmodule

// File: doc/npc_pc_unit.md
Name: npc_pc_unit

Overview:
- Program-counter stage: holds PC, computes next PC, advances it once per retired instruction.
- Consumes the ALU Zero flag to resolve conditional branches.
- Supplies the instruction-memory fetch address and the link value for jal.
- Adds HALT/TRAP state tracking and a retired-instruction counter for bench end-of-test detection.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- INSTRET_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- NPCOp  input  3  next-PC select: 000 PC4, 001 BEQ, 010 J/JAL, 011 JR, 100 BNE (macro), others PC4.
- Zero  input  1  ALU equality flag (num_1 == num_2).
- imm16  input  16  branch offset, in words.
- target26  input  26  jump index field.
- rs_data  input  32  register value used as the jr target.
- stall  input  1  hold PC; current instruction does not retire.
- halt_req  input  1  decoded syscall/halt for the current instruction.
- pc  output  32  current fetch address.
- pc_plus4  output  32  pc+4, combinational; jal link value.
- halted  output  1  HALT state indicator.
- trap  output  1  TRAP state indicator.
- trap_pc  output  32  PC of the faulting jr.
- instret  output  INSTRET_W  count of retired instructions.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=RUN, halted=0, trap=0, trap_pc=0, instret=0.
  - Reset asserted mid-operation overrides every state immediately.
- Next-PC computation (combinational, 32-bit, wrap modulo 2^32):
  - PC4: pc+4.
  - BEQ: Zero ? pc+4+(sign_ext(imm16)<<2) : pc+4.
  - J: {pc_plus4[31:28], target26, 2'b00}.
  - JR: rs_data.
- States: RUN, HALT, TRAP. Each clock edge in RUN, evaluated in priority order:
  1. stall=1: no change to pc, state or instret. halt_req and misaligned jr are ignored, because the instruction is not retiring.
  2. halt_req=1: state -> HALT, pc unchanged, instret+1 (the syscall retires).
  3. NPCOp=JR and rs_data[1:0]!=0: state -> TRAP, trap_pc <= pc, pc unchanged, instret unchanged.
  4. Otherwise: pc <= npc, instret+1.
- HALT and TRAP are terminal until reset. pc, instret and trap_pc are frozen; all inputs are ignored.
- Outputs: halted=(state==HALT), trap=(state==TRAP), both registered.
- Latency:
  - pc updates on the edge after the control inputs are presented; the branch decision uses Zero from the same cycle.
  - pc_plus4 and npc have zero latency.
- Boundaries:
  - pc=32'hFFFF_FFFC with PC4 wraps to 0.
  - imm16=16'h8000 gives a backward offset of -131072 bytes.
  - instret wraps from all-ones to 0.
- No misalignment check on branch or J targets; they are aligned by construction.

Optional Feature:
- Macro NPC_BNE_EN.
- Defined: NPCOp=100 is BNE, next PC = Zero ? pc+4 : pc+4+(sign_ext(imm16)<<2).
- Undefined: NPCOp=100 decodes as PC4.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then 3 cycles of PC4, no stall -> pc 3000, 3004, 3008, 300C; instret=3.
- At pc=3010: BEQ, imm16=0004, Zero=1 -> pc=3024. Same inputs with Zero=0 -> pc=3014.
- At pc=3020: JR, rs_data=0000_3002 -> trap=1, trap_pc=3020, pc stays 3020. Further PC4 cycles leave pc unchanged.
- halt_req=1 with stall=1 -> no change. The next cycle with stall=0 -> halted=1, instret+1, pc frozen. rst_n pulse mid-HALT -> pc=3000, halted=0.
- At pc=0000_3000: J, target26=0000C40 -> pc=0000_3100. At pc=FFFF_FFFC: PC4 -> pc=0000_0000.
- NPC_BNE_EN defined, NPCOp=100, imm16=FFFF, Zero=0 at pc=3040 -> pc=3040. NPC_BNE_EN undefined, same inputs -> pc=3044.
